// File: rtl/spi_master.sv
// SPI mode-0 master issuing 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first, via start/done.
// Optional macro SPI_MASTER_BUSY_ERR_EN: pulse err when start arrives while busy.
module spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       err,
   output logic       cs_n,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] shift_q, shift_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rw_q, rw_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        div_end;

   assign div_end = (div_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         rw_q    <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         rw_q    <= rw_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      rw_d    = rw_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = {rw, addr, rw ? 8'h00 : wdata};
               rw_d    = rw;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               busy_d  = 1'b1;
               div_d   = '0;
               bit_d   = 4'd15;
               rx_d    = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_end) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // Falling edge: sample miso from the ending high phase and present the next bit.
               // Shifting in zeros leaves mosi low once the last bit has gone out.
               if (sclk_q) begin
                  shift_d = {shift_q[14:0], 1'b0};
                  if (rw_q && !bit_q[3]) begin
                     rx_d = {rx_q[6:0], miso};
                  end
                  if (bit_q == 4'd0) begin
                     state_d = HOLD;
                  end else begin
                     bit_d = bit_q - 4'd1;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         HOLD: begin
            if (div_end) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               if (rw_q) begin
                  rdata_d = rx_q;
               end
               state_d = GAP;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         GAP: begin
            if (div_end) begin
               div_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign cs_n  = cs_n_q;
   assign sclk  = sclk_q;
   assign mosi  = shift_q[15];

`ifdef SPI_MASTER_BUSY_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= start && busy_q;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_DIV=4 and 2), a cycle-indexed
// timing model, an SPI slave model and a scoreboard of expected mosi frames.
module tb_spi_master;

   localparam int D0 = 4;
   localparam int D1 = 2;
`ifdef SPI_MASTER_BUSY_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic       rw    [2];
   logic [6:0] addr  [2];
   logic [7:0] wdata [2];
   logic       busy  [2];
   logic       done  [2];
   logic [7:0] rdata [2];
   logic       err   [2];
   logic       cs_n  [2];
   logic       sclk  [2];
   logic       mosi  [2];
   logic       miso  [2];

   int          total;
   int          bad;
   logic [15:0] exp_q[$];
   logic [7:0]  model_rdata [2];

   // clock / reset
   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(D0)) u_div4 (
      .clk(clk), .rst(rst), .start(start[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
      .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]),
      .cs_n(cs_n[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
   );

   spi_master #(.CLK_DIV(D1)) u_div2 (
      .clk(clk), .rst(rst), .start(start[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
      .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]),
      .cs_n(cs_n[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {cs_n, sclk, mosi, busy, done, err, rdata}
   function automatic logic [13:0] outs(input int u);
      return {cs_n[u], sclk[u], mosi[u], busy[u], done[u], err[u], rdata[u]};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame on instance u starting in the current cycle (T) and checks every cycle
   // up to T+34*d+1, where busy must first read 0. probe_c>0 pulses a stray start in cycle
   // T+probe_c; rst_c>0 asserts reset in cycle T+rst_c and aborts the frame.
   task automatic frame(input int u, input logic f_rw, input logic [6:0] f_addr,
                        input logic [7:0] f_wdata, input logic [7:0] s_byte,
                        input int probe_c, input int rst_c);
      int          d;
      int          rises;
      int          falls;
      int          gap;
      int          dones;
      logic [15:0] word;
      logic [15:0] cap;
      logic        prev_sclk;
      logic        e_cs, e_sc, e_mo, e_bs, e_dn, e_er;
      logic [7:0]  e_rd;
      d         = (u == 0) ? D0 : D1;
      word      = {f_rw, f_addr, f_rw ? 8'h00 : f_wdata};
      cap       = '0;
      rises     = 0;
      falls     = 0;
      gap       = 0;
      dones     = 0;
      prev_sclk = 1'b0;
      exp_q.push_back(word);
      start[u] = 1'b1;
      rw[u]    = f_rw;
      addr[u]  = f_addr;
      wdata[u] = f_wdata;
      for (int c = 1; c <= 34 * d + 1; c++) begin
         @(posedge clk);
         #1;
         if (rst_c > 0 && c == rst_c + 1) begin
            check("rst_abort_u0", 32'(outs(0)), 32'(14'b10_0000_0000_0000));
            check("rst_abort_u1", 32'(outs(1)), 32'(14'b10_0000_0000_0000));
            rst            = 1'b0;
            miso[u]        = 1'b0;
            start[u]       = 1'b0;
            model_rdata[0] = 8'h00;
            model_rdata[1] = 8'h00;
            for (int k = 0; k < 40 * d; k++) begin
               @(posedge clk);
               #1;
               check("post_rst_idle", 32'(outs(u)), 32'(14'b10_0000_0000_0000));
            end
            void'(exp_q.pop_back());
            return;
         end
         e_cs = !(c <= 33 * d);
         e_sc = (c <= 32 * d) && (((c - 1) / d) % 2 == 1);
         e_mo = (c <= 32 * d) ? word[15 - (c - 1) / (2 * d)] : 1'b0;
         e_bs = (c <= 34 * d);
         e_dn = (c == 33 * d + 1);
         e_er = ERR_EN && probe_c > 0 && c == probe_c + 1;
         e_rd = (f_rw && c >= 33 * d + 1) ? s_byte : model_rdata[u];
         check("cycle", 32'(outs(u)), 32'({e_cs, e_sc, e_mo, e_bs, e_dn, e_er, e_rd}));
         // slave model: capture mosi on rising sclk, present read data after falling sclk
         if (!prev_sclk && sclk[u]) begin
            cap = {cap[14:0], mosi[u]};
            rises++;
         end
         if (prev_sclk && !sclk[u]) begin
            falls++;
            miso[u] = (falls >= 8 && falls <= 15) ? s_byte[15 - falls] : 1'b0;
         end
         prev_sclk = sclk[u];
         if (cs_n[u] && busy[u]) gap++;
         if (done[u]) dones++;
         start[u] = (c == probe_c);
         if (c == probe_c) begin
            rw[u]    = 1'($urandom_range(0, 1));
            addr[u]  = 7'($urandom_range(0, 127));
            wdata[u] = 8'($urandom_range(0, 255));
         end
         if (rst_c > 0 && c == rst_c) rst = 1'b1;
      end
      check("mosi_frame", 32'(cap), 32'(exp_q.pop_front()));
      check("sclk_rises", rises, 16);
      check("gap_cycles", gap, d);
      check("done_count", dones, 1);
      if (f_rw) model_rdata[u] = s_byte;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      for (int u = 0; u < 2; u++) begin
         start[u]       = 1'b0;
         rw[u]          = 1'b0;
         addr[u]        = '0;
         wdata[u]       = '0;
         miso[u]        = 1'b0;
         model_rdata[u] = 8'h00;
      end
      idle(3);
      check("reset_u0", 32'(outs(0)), 32'(14'b10_0000_0000_0000));
      check("reset_u1", 32'(outs(1)), 32'(14'b10_0000_0000_0000));
      rst = 1'b0;
      idle(2);

      frame(0, 1'b0, 7'h05, 8'hA3, 8'h00, 0, 0);   // write 0x05A3
      idle(2);
      frame(0, 1'b1, 7'h10, 8'h55, 8'h3C, 0, 0);   // read -> mosi 0x9000, rdata 0x3C
      frame(0, 1'b0, 7'h7F, 8'h01, 8'h00, 0, 0);   // back-to-back with previous
      frame(0, 1'b1, 7'h2A, 8'h00, 8'hC5, 50, 0);  // stray start at T+50
      idle(1);
      frame(0, 1'b0, 7'h33, 8'h99, 8'h00, 0, 40);  // reset at T+40
      frame(0, 1'b1, 7'h44, 8'h00, 8'h81, 0, 0);   // recovery after reset
      idle(3);
      frame(1, 1'b1, 7'h01, 8'h00, 8'hFF, 0, 0);   // CLK_DIV=2 read of 0xFF
      frame(1, 1'b0, 7'h00, 8'hFF, 8'h00, 0, 0);
      frame(1, 1'b1, 7'h7F, 8'h00, 8'h00, 30, 0);

      for (int i = 0; i < 16; i++) begin
         int u;
         u = int'($urandom_range(0, 1));
         frame(u, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 60)) : 0, 0);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
